// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one load/store at a time to a handshaked
// data memory, stalls upstream while waiting, and registers writeback results.
module mem_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] aluIn,
    input  logic [31:0] storeData,
    input  logic [1:0]  memOp,
    input  logic [2:0]  funct3,
    input  logic        aluToRegIn,
    input  logic [4:0]  rdIn,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memBe,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic [31:0] aluOut,
    output logic [31:0] memOut,
    output logic        readValid,
    output logic        aluToReg,
    output logic [4:0]  rd,
    output logic        stall,
    output logic        misaligned
);

    typedef enum logic {IDLE, REQ} stateT;

    stateT       state;
    logic [31:0] addrReg;
    logic [31:0] wdataReg;
    logic [3:0]  beReg;
    logic        weReg;
    logic [2:0]  funct3Reg;
    logic [4:0]  rdReg;

    logic        isLoad;
    logic        isStore;
    logic        funct3Ok;
    logic        aligned;
    logic        legal;
    logic [3:0]  beNext;
    logic [31:0] wdataNext;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] loadData;

    // Decode the incoming op; "legal" means a load/store that may be issued.
    always_comb begin
        isLoad   = (memOp == 2'b01);
        isStore  = (memOp == 2'b10);
        funct3Ok = 1'b0;
        if (isLoad) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3Ok = 1'b1;
                default:                                funct3Ok = 1'b0;
            endcase
        end else if (isStore) begin
            funct3Ok = (funct3 < 3'b011);
        end
        case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~aluIn[0];
            2'b10:   aligned = (aluIn[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        legal = (isLoad | isStore) & funct3Ok & aligned;
    end

    always_comb begin
        beNext    = 4'b1111;
        wdataNext = storeData;
        if (isStore) begin
            case (funct3[1:0])
                2'b00: begin
                    beNext    = 4'b0001 << aluIn[1:0];
                    wdataNext = {4{storeData[7:0]}};
                end
                2'b01: begin
                    beNext    = aluIn[1] ? 4'b1100 : 4'b0011;
                    wdataNext = {2{storeData[15:0]}};
                end
                default: begin
                    beNext    = 4'b1111;
                    wdataNext = storeData;
                end
            endcase
        end
    end

    // Lane selection uses the captured address, since aluIn may have moved on.
    always_comb begin
        case (addrReg[1:0])
            2'b00:   laneByte = memRdata[7:0];
            2'b01:   laneByte = memRdata[15:8];
            2'b10:   laneByte = memRdata[23:16];
            default: laneByte = memRdata[31:24];
        endcase
        laneHalf = addrReg[1] ? memRdata[31:16] : memRdata[15:0];
        case (funct3Reg)
            3'b000:  loadData = {{24{laneByte[7]}}, laneByte};
            3'b001:  loadData = {{16{laneHalf[15]}}, laneHalf};
            3'b100:  loadData = {24'd0, laneByte};
            3'b101:  loadData = {16'd0, laneHalf};
            default: loadData = memRdata;
        endcase
    end

    assign memReq   = (state == REQ);
    assign memWe    = weReg;
    assign memAddr  = {addrReg[31:2], 2'b00};
    assign memWdata = wdataReg;
    assign memBe    = beReg;
    assign stall    = ~reset & (((state == IDLE) & valid & legal) | ((state == REQ) & ~memAck));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            readValid  <= 1'b0;
            aluToReg   <= 1'b0;
            misaligned <= 1'b0;
            rd         <= 5'd0;
            aluOut     <= 32'd0;
            memOut     <= 32'd0;
            addrReg    <= 32'd0;
            wdataReg   <= 32'd0;
            beReg      <= 4'd0;
            weReg      <= 1'b0;
            funct3Reg  <= 3'd0;
            rdReg      <= 5'd0;
        end else begin
            readValid  <= 1'b0;
            aluToReg   <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        if (isLoad | isStore) begin
                            if (legal) begin
                                addrReg   <= aluIn;
                                wdataReg  <= wdataNext;
                                beReg     <= beNext;
                                weReg     <= isStore;
                                funct3Reg <= funct3;
                                rdReg     <= rdIn;
                                state     <= REQ;
                            end else begin
                                misaligned <= 1'b1;
                            end
                        end else begin
                            aluOut   <= aluIn;
                            aluToReg <= aluToRegIn;
                            rd       <= rdIn;
                        end
                    end
                end
                REQ: begin
                    if (memAck) begin
                        state <= IDLE;
                        if (!weReg) begin
                            memOut    <= loadData;
                            readValid <= 1'b1;
                            rd        <= rdReg;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
